pdm_modulator: RTL
==================

Name: pdm_modulator

Overview:
PCM-to-PDM transmitter, the output-side counterpart of the pdm_mic capture path. It accepts signed PCM samples through a valid/ready stream into a small FIFO. Each sample is held for INTERP PDM periods (zero-order hold), and a first-order sigma-delta accumulator converts it to a 1-bit PDM stream. The block also generates its own PDM bit clock from the system clock and drives an external PDM amplifier or filter pin.

Parameters:
IN_FREQ, 100_000_000, system clock frequency in Hz
OUT_FREQ, 480_000, PDM bit-clock frequency in Hz
INTERP, 10, PDM periods per PCM sample (480 kHz / 10 = 48 kHz)
SAMPLE_WIDTH, 16, PCM sample width, two's complement
FIFO_DEPTH, 4, sample FIFO entries (power of two, at least 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low = idle, and the FIFO retains its contents
s_data  in  SAMPLE_WIDTH  signed PCM sample
s_valid  in  1  sample valid
s_ready  out  1  FIFO can accept a sample
pdm_clk  out  1  PDM bit clock, 50% duty
pdm_clk_rising  out  1  one-cycle pulse in the cycle pdm_clk becomes 1
pdm_data  out  1  PDM bit; changes only on the pdm_clk falling transition
underrun  out  1  one-cycle pulse: FIFO empty when a new sample was due
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: pdm_clk=0, pdm_clk_rising=0, pdm_data=0, underrun=0, fifo_level=0. Internally: half-period count=0, step count icnt=0, accumulator acc=0, held sample cur=0. s_ready=0 while rst is high.
- HALF = IN_FREQ/(2*OUT_FREQ), integer division (default 104). The half-period counter runs 0..HALF-1 while en=1.
  - When the count is at HALF-1, the next cycle clears it and toggles pdm_clk.
  - After rst deassert with en=1, pdm_clk first rises in cycle 104 (pdm_clk_rising=1 in that cycle) and first falls in cycle 208. The period is 208 cycles.
- en=0: the counter, icnt, acc and pdm_clk are cleared; pdm_data=0; cur is kept. When en is raised again, timing restarts exactly as after reset. The FIFO keeps accepting samples while en=0.
- Modulator step: occurs only in the cycle pdm_clk goes 1->0.
  - Sample used: x = popped head if a pop happens this step, else cur.
  - Conversion: u = x + 2^(SAMPLE_WIDTH-1), i.e. x with its MSB inverted, giving unsigned offset binary.
  - Update: {carry, acc} <= acc + u, computed SAMPLE_WIDTH+1 bits wide; pdm_data <= carry, registered in the same cycle pdm_clk falls.
- Sample fetch happens on steps where icnt==0; icnt wraps 0..INTERP-1, advancing once per step.
  - FIFO non-empty: pop, cur <= head, and this step uses the head.
  - FIFO empty: underrun pulses for one cycle, cur is unchanged (repeat last sample), and icnt still advances.
- FIFO:
  - s_ready = !rst && (fifo_level < FIFO_DEPTH), from registered occupancy. A push occurs when s_valid && s_ready.
  - Push and pop in the same cycle: level is unchanged. When full, s_ready=0 even if a pop occurs that cycle.
  - Push into an empty FIFO in a fetch cycle: the pop sees empty, underrun fires, and the pushed sample becomes the head for the next fetch.
  - Pointers wrap modulo FIFO_DEPTH.
- Density: x=0 gives 50% ones; x=+32767 gives 65535/65536 ones; x=-32768 gives all zeros.

Decomposition:
- Package pdm_pkg holds:
  - sample_t (logic signed [SAMPLE_WIDTH-1:0]);
  - function half_div(IN_FREQ, OUT_FREQ);
  - function to_offset(sample_t) for the MSB inversion.
- Sub-module pcm_fifo: synchronous FIFO with push/pop/level, no fall-through. The head is a registered read of the mem[rd_ptr] output.
- Clock divider, step counter and accumulator stay in pdm_modulator.

Test Plan:
- Reset, then en=1 with no samples -> pdm_clk rises at cycle 104 and period is 208. underrun pulses at the first step (cycle 208) and again every 10 steps. pdm_data from x=0 is 0,1,0,1,...
- Push 0x0000, 0x7FFF, 0x8000, 0x4000 back-to-back -> fifo_level reaches 4 and s_ready drops. Each value is held for exactly 10 steps. 0x8000 (-32768) gives pdm_data=0 for all 10 steps.
- Constant 0x4000 (u=0xC000) from acc=0 -> ones density 0.75, first 4 bits 0,1,1,1, ones count 7 or 8 per 10 steps.
- Push during a full-FIFO fetch cycle -> push rejected (s_ready=0), pop occurs, level 4→3, s_ready=1 next cycle.
- Drop en for 50 cycles mid-sample, then raise -> pdm_clk/pdm_data held 0 while low. Next rising edge is 104 cycles after re-enable. FIFO contents are unchanged and the first step fetches a new sample.
- Assert rst mid-stream with 3 samples queued -> next cycle fifo_level=0, all outputs at reset values, s_ready=1 one cycle after deassert.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PCM-to-PDM transmit path.
//   PCM_W      : native PCM sample width
//   sample_t   : signed PCM sample
//   half_div   : system-clock cycles per half PDM bit-clock period
//   to_offset  : two's complement -> offset binary (MSB inversion)
package pdm_pkg;

    localparam int PCM_W = 16;

    typedef logic signed [PCM_W-1:0] sample_t;

    function automatic int half_div(input int in_freq, input int out_freq);
        return in_freq / (2 * out_freq);
    endfunction

    function automatic logic [PCM_W-1:0] to_offset(input sample_t s);
        return {~s[PCM_W-1], s[PCM_W-2:0]};
    endfunction

endpackage

// File: rtl/pdm_modulator_fifo.sv
// pcm_fifo: synchronous sample FIFO with occupancy count, no fall-through.
//   clk, rst : system clock, synchronous active-high reset
//   push/din : write request and data (ignored when full)
//   pop      : read request (ignored when empty)
//   dout     : current head entry (register array read at rd_ptr)
//   level    : number of entries held
module pcm_fifo
    import pdm_pkg::*;
#(
    parameter int WIDTH = PCM_W,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (level < LVL_W'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_modulator.sv
// pdm_modulator: PCM-to-PDM transmitter. Samples enter a small FIFO, each is
// held for INTERP PDM periods and fed to a first-order sigma-delta
// accumulator whose carry is the PDM bit. The PDM bit clock is divided down
// from clk.
//   clk, rst        : system clock, synchronous active-high reset
//   en              : run enable (low = idle, FIFO keeps its contents)
//   s_data/s_valid  : signed PCM sample stream in
//   s_ready         : FIFO can accept a sample
//   pdm_clk         : PDM bit clock, 50% duty
//   pdm_clk_rising  : one-cycle pulse in the cycle pdm_clk becomes 1
//   pdm_data        : PDM bit, updated only as pdm_clk falls
//   underrun        : one-cycle pulse when a sample was due but FIFO empty
//   fifo_level      : FIFO occupancy
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int IN_FREQ      = 100_000_000,
    parameter int OUT_FREQ     = 480_000,
    parameter int INTERP       = 10,
    parameter int SAMPLE_WIDTH = PCM_W,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           pdm_clk,
    output logic                           pdm_clk_rising,
    output logic                           pdm_data,
    output logic                           underrun,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int HALF   = half_div(IN_FREQ, OUT_FREQ);
    localparam int HCNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int ICNT_W = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [HCNT_W-1:0]              hcnt;
    logic [ICNT_W-1:0]              icnt;
    logic [SAMPLE_WIDTH-1:0]        acc;
    logic signed [SAMPLE_WIDTH-1:0] cur;
    logic [SAMPLE_WIDTH-1:0]        head;
    logic signed [SAMPLE_WIDTH-1:0] x;
    logic [SAMPLE_WIDTH-1:0]        u;
    logic [SAMPLE_WIDTH:0]          sum;
    logic                           push;
    logic                           last_half;
    logic                           step;
    logic                           fetch;
    logic                           pop;

    assign s_ready = !rst && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;

    pcm_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (s_data),
        .pop   (pop),
        .dout  (head),
        .level (fifo_level)
    );

    // A modulator step is the cycle in which pdm_clk is about to fall.
    assign last_half = (hcnt == HCNT_W'(HALF - 1));
    assign step      = en && last_half && pdm_clk;
    assign fetch     = step && (icnt == '0);
    assign pop       = fetch && (fifo_level != '0);

    // A freshly popped head is used in the very step that pops it.
    assign x = pop ? $signed(head) : cur;

    if (SAMPLE_WIDTH == PCM_W) begin : g_pkg_offset
        assign u = to_offset(x);
    end else begin : g_generic_offset
        assign u = {~x[SAMPLE_WIDTH-1], x[SAMPLE_WIDTH-2:0]};
    end

    // The carry out of the accumulator is the PDM bit.
    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt           <= '0;
            icnt           <= '0;
            acc            <= '0;
            cur            <= '0;
            pdm_clk        <= 1'b0;
            pdm_clk_rising <= 1'b0;
            pdm_data       <= 1'b0;
            underrun       <= 1'b0;
        end else if (!en) begin
            // Idle: timing restarts from scratch on re-enable; cur survives.
            hcnt           <= '0;
            icnt           <= '0;
            acc            <= '0;
            pdm_clk        <= 1'b0;
            pdm_clk_rising <= 1'b0;
            pdm_data       <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            pdm_clk_rising <= 1'b0;
            underrun       <= 1'b0;
            if (last_half) begin
                hcnt           <= '0;
                pdm_clk        <= ~pdm_clk;
                pdm_clk_rising <= ~pdm_clk;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            if (step) begin
                acc      <= sum[SAMPLE_WIDTH-1:0];
                pdm_data <= sum[SAMPLE_WIDTH];
                underrun <= fetch && (fifo_level == '0);
                if (icnt == ICNT_W'(INTERP - 1)) begin
                    icnt <= '0;
                end else begin
                    icnt <= icnt + 1'b1;
                end
                if (pop) begin
                    cur <= $signed(head);
                end
            end
        end
    end

endmodule
